// File: rtl/tag_mem_array_if.sv
// tag_mem_array_if: tag memory bus between the interface (master) and the memory array (slave); TAG_MEM_PARITY_EN adds parity signals
interface tag_mem_array_if #(parameter int DATA_W = 16, parameter int ADDR_W = 6);
  logic factory_reset;
  logic [2:0] mem_sel;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0] RorW;
  logic PC_B;
  logic SE;
  logic WE;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_read_in;
  logic access_done;
  logic busy;
  logic protocol_err;
`ifdef TAG_MEM_PARITY_EN
  logic parity_inject;
  logic parity_err;
  modport master(output factory_reset, mem_sel, mem_address, RorW, PC_B, SE, WE, mem_data_out, parity_inject,
                 input mem_read_in, access_done, busy, protocol_err, parity_err);
  modport slave(input factory_reset, mem_sel, mem_address, RorW, PC_B, SE, WE, mem_data_out, parity_inject,
                output mem_read_in, access_done, busy, protocol_err, parity_err);
`else
  modport master(output factory_reset, mem_sel, mem_address, RorW, PC_B, SE, WE, mem_data_out,
                 input mem_read_in, access_done, busy, protocol_err);
  modport slave(input factory_reset, mem_sel, mem_address, RorW, PC_B, SE, WE, mem_data_out,
                output mem_read_in, access_done, busy, protocol_err);
`endif
endinterface

// File: rtl/tag_mem_array.sv
// tag_mem_array: 3-bank tag memory responder with strobe FSM, factory sweep and protocol checks; TAG_MEM_PARITY_EN adds word parity
module tag_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic clk,
  input logic reset,
  tag_mem_array_if.slave bus
);
`ifdef TAG_MEM_PARITY_EN
  localparam int WW = DATA_W + 1;
`else
  localparam int WW = DATA_W;
`endif
  typedef enum logic [2:0] {IDLE, PRECH, READ, WRITE, RECOV, SWEEP} state_t;
  state_t state, nxt;
  logic [WW-1:0] mem [3][DEPTH];
  logic [1:0] bank_q, bank_in, rw_q, rw_eff;
  logic [ADDR_W-1:0] addr_q, cnt;
  logic pw_q, acc_req, sel_ok, addr_ok, in_acc, rd_go, wr_go, err_now, err_set, ld, wr, rd_done;
  logic [WW-1:0] rd_word, wr_word;
  assign acc_req = !bus.PC_B && (bus.RorW == 2'b01 || bus.RorW == 2'b10);
  assign sel_ok = bus.mem_sel inside {3'b001, 3'b010, 3'b100};
  assign addr_ok = {1'b0, bus.mem_address} < (ADDR_W+1)'(DEPTH);
  assign bank_in = bus.mem_sel[2] ? 2'd2 : bus.mem_sel[1] ? 2'd1 : 2'd0;
  assign in_acc = state inside {PRECH, READ, WRITE};
  assign rw_eff = in_acc ? rw_q : bus.RorW;
  assign rd_go = bus.PC_B && bus.SE && rw_q == 2'b01;
  assign wr_go = bus.PC_B && bus.WE && rw_q == 2'b10;
  assign rd_word = mem[bank_in][bus.mem_address];
  // Any violation in the current cycle also cancels whatever access it belongs to
  assign err_now = (acc_req && (state == SWEEP || (state == IDLE && !(sel_ok && addr_ok))))
                || (bus.SE && bus.WE)
                || (bus.WE && !(state inside {PRECH, WRITE}))
                || (bus.SE && rw_eff == 2'b10);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bank_q <= '0;
      addr_q <= '0;
      rw_q <= '0;
      pw_q <= 1'b0;
      cnt <= '0;
      bus.mem_read_in <= '0;
      bus.access_done <= 1'b0;
      bus.protocol_err <= 1'b0;
    end else begin
      state <= nxt;
      pw_q <= state == PRECH && nxt == PRECH;
      cnt <= state == SWEEP && !bus.factory_reset ? cnt + 1'b1 : '0;
      bus.access_done <= wr || rd_done;
      if (err_set) bus.protocol_err <= 1'b1;
      if (state == IDLE && nxt == PRECH) begin
        bank_q <= bank_in;
        addr_q <= bus.mem_address;
        rw_q <= bus.RorW;
      end
      if (ld) bus.mem_read_in <= rd_word[DATA_W-1:0];
    end
  end
  always_comb begin
    nxt = state;
    if (bus.factory_reset) nxt = SWEEP;
    else case (state)
      IDLE:        nxt = acc_req && !err_now ? PRECH : IDLE;
      PRECH:       nxt = err_now ? IDLE : rd_go ? READ : wr_go ? WRITE : pw_q ? IDLE : PRECH;
      READ, WRITE: nxt = err_now ? IDLE : (!bus.SE && !bus.WE) ? RECOV : state;
      RECOV:       nxt = IDLE;
      SWEEP:       nxt = cnt == ADDR_W'(DEPTH - 1) ? IDLE : SWEEP;
      default:     nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state == SWEEP;
    ld = state == IDLE && nxt == PRECH && bus.RorW == 2'b01;
    wr = state == PRECH && nxt == WRITE;
    rd_done = state == PRECH && nxt == READ;
    err_set = err_now || (state == PRECH && nxt == IDLE);
  end
  // Reset wins over a commit or sweep step landing on the same edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == SWEEP) for (int b = 0; b < 3; b++) mem[b][cnt] <= '0;
      else if (wr) mem[bank_q][addr_q] <= wr_word;
    end
  end
`ifdef TAG_MEM_PARITY_EN
  logic inj_q;
  assign wr_word = {^bus.mem_data_out ^ (inj_q | bus.parity_inject), bus.mem_data_out};
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_q <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      inj_q <= (inj_q || bus.parity_inject) && !wr;
      bus.parity_err <= ld && ^rd_word;
    end
  end
`else
  assign wr_word = bus.mem_data_out;
`endif
endmodule

// File: tb/tb_tag_mem_array.sv
// tb_tag_mem_array: randomized bus transactions checked against a per-bank word-array reference model
module tb_tag_mem_array;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] ref_mem [3][DEPTH];
  logic [2:0] sels [3] = '{3'b001, 3'b010, 3'b100};
  logic [2:0] bad_sels [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
  tag_mem_array_if #(.DATA_W(16), .ADDR_W(6)) bus();
  tag_mem_array #(.DATA_W(16), .ADDR_W(6), .DEPTH(DEPTH)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.PC_B = 1'b1;
    bus.SE = 1'b0;
    bus.WE = 1'b0;
    bus.RorW = 2'b00;
    bus.factory_reset = 1'b0;
`ifdef TAG_MEM_PARITY_EN
    bus.parity_inject = 1'b0;
`endif
  endtask

  function automatic int perr();
`ifdef TAG_MEM_PARITY_EN
    return int'(bus.parity_err);
`else
    return 0;
`endif
  endfunction

  task automatic wr_op(input logic [2:0] sel, input logic [5:0] a, input logic [15:0] d, input bit inj, output int done);
    bus.mem_sel = sel;
    bus.mem_address = a;
    bus.mem_data_out = d;
    bus.RorW = 2'b10;
    bus.PC_B = 1'b0;
    tick();
    done = int'(bus.access_done);
    bus.PC_B = 1'b1;
    bus.WE = 1'b1;
`ifdef TAG_MEM_PARITY_EN
    bus.parity_inject = inj;
`endif
    tick();
    done += int'(bus.access_done);
    idle_bus();
    tick();
    done += int'(bus.access_done);
    tick();
    done += int'(bus.access_done);
  endtask

  task automatic rd_op(input logic [2:0] sel, input logic [5:0] a, output logic [15:0] d, output int done, output int pe);
    bus.mem_sel = sel;
    bus.mem_address = a;
    bus.RorW = 2'b01;
    bus.PC_B = 1'b0;
    tick();
    d = bus.mem_read_in;
    done = int'(bus.access_done);
    pe = perr();
    bus.PC_B = 1'b1;
    bus.SE = 1'b1;
    tick();
    done += int'(bus.access_done);
    pe += perr();
    idle_bus();
    tick();
    done += int'(bus.access_done);
    pe += perr();
    tick();
    done += int'(bus.access_done);
    pe += perr();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] d, saved;
    int done, done2, pe, n, b, a;
    idle_bus();
    bus.mem_sel = 3'b001;
    bus.mem_address = '0;
    bus.mem_data_out = '0;
    tick();
    tick();
    check("rst_read_data", bus.mem_read_in, 0);
    check("rst_done", bus.access_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.protocol_err, 0);
    reset = 1'b0;
    tick();
    wr_op(3'b001, 6'd5, 16'hA5C3, 1'b0, done);
    ref_mem[0][5] = 16'hA5C3;
    rd_op(3'b001, 6'd5, d, done2, pe);
    check("epc_read", d, 16'hA5C3);
    check("epc_done_pulses", done + done2, 2);
    wr_op(3'b010, 6'd0, 16'h1234, 1'b0, done);
    wr_op(3'b100, 6'd0, 16'h5678, 1'b0, done);
    wr_op(3'b001, 6'd0, 16'h0F0F, 1'b0, done);
    ref_mem[1][0] = 16'h1234;
    ref_mem[2][0] = 16'h5678;
    ref_mem[0][0] = 16'h0F0F;
    rd_op(3'b010, 6'd0, d, done, pe);
    check("s1_alias", d, 16'h1234);
    rd_op(3'b100, 6'd0, d, done, pe);
    check("s2_alias", d, 16'h5678);
    rd_op(3'b001, 6'd0, d, done, pe);
    check("epc_alias", d, 16'h0F0F);
    wr_op(3'b001, 6'd7, 16'hAAAA, 1'b0, done);
    wr_op(3'b010, 6'd7, 16'hBBBB, 1'b0, done);
    check("err_clean", bus.protocol_err, 0);
    wr_op(3'b011, 6'd7, 16'hFFFF, 1'b0, done);
    check("badsel_done", done, 0);
    check("badsel_err", bus.protocol_err, 1);
    rd_op(3'b001, 6'd7, d, done, pe);
    check("badsel_epc_keep", d, 16'hAAAA);
    rd_op(3'b010, 6'd7, d, done, pe);
    check("badsel_s1_keep", d, 16'hBBBB);
    check("err_sticky", bus.protocol_err, 1);
    pulse_reset();
    check("err_cleared", bus.protocol_err, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      d = 16'($urandom);
      wr_op(sels[i / DEPTH], 6'(i % DEPTH), d, 1'b0, done);
      ref_mem[i / DEPTH][i % DEPTH] = d;
    end
    bus.factory_reset = 1'b1;
    tick();
    bus.factory_reset = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    check("sweep_busy_cycles", n, DEPTH);
    for (int i = 0; i < 3 * DEPTH; i++) ref_mem[i / DEPTH][i % DEPTH] = '0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rd_op(sels[i / DEPTH], 6'(i % DEPTH), d, done, pe);
      check("sweep_zero", d, 0);
    end
    check("sweep_no_err", bus.protocol_err, 0);
    saved = bus.mem_read_in;
    bus.factory_reset = 1'b1;
    tick();
    bus.factory_reset = 1'b0;
    tick();
    tick();
    bus.mem_sel = 3'b001;
    bus.mem_address = 6'd9;
    bus.RorW = 2'b01;
    bus.PC_B = 1'b0;
    tick();
    idle_bus();
    tick();
    check("busy_read_err", bus.protocol_err, 1);
    check("busy_read_ignored", bus.mem_read_in, saved);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    check("sweep2_ends", bus.busy, 0);
    pulse_reset();
    check("err_cleared2", bus.protocol_err, 0);
    for (int i = 0; i < 300; i++) begin
      b = $urandom_range(0, 2);
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 9);
      if (n == 0) begin
        wr_op(bad_sels[$urandom_range(0, 4)], 6'(a), 16'($urandom), 1'b0, done);
        check("rnd_bad_done", done, 0);
        check("rnd_bad_err", bus.protocol_err, 1);
        pulse_reset();
      end else if (n < 5) begin
        d = 16'($urandom);
        wr_op(sels[b], 6'(a), d, 1'b0, done);
        ref_mem[b][a] = d;
        check("rnd_wr_done", done, 1);
      end else begin
        rd_op(sels[b], 6'(a), d, done, pe);
        check("rnd_rd_data", d, ref_mem[b][a]);
        check("rnd_rd_done", done, 1);
        check("rnd_rd_parity", pe, 0);
      end
      check("rnd_err", bus.protocol_err, 0);
    end
    wr_op(3'b001, 6'd2, 16'h1111, 1'b0, done);
    ref_mem[0][2] = 16'h1111;
    rd_op(3'b001, 6'd2, d, done, pe);
    check("pre_abort_read", d, 16'h1111);
    bus.mem_sel = 3'b001;
    bus.mem_address = 6'd2;
    bus.mem_data_out = 16'hBEEF;
    bus.RorW = 2'b10;
    bus.PC_B = 1'b0;
    tick();
    bus.PC_B = 1'b1;
    bus.WE = 1'b1;
    reset = 1'b1;
    tick();
    check("abort_done", bus.access_done, 0);
    check("abort_read_data", bus.mem_read_in, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_err", bus.protocol_err, 0);
    reset = 1'b0;
    idle_bus();
    tick();
    rd_op(3'b001, 6'd2, d, done, pe);
    check("abort_no_write", d, 16'h1111);
`ifdef TAG_MEM_PARITY_EN
    wr_op(3'b001, 6'd3, 16'h3C3C, 1'b1, done);
    wr_op(3'b001, 6'd4, 16'h4D4D, 1'b0, done);
    rd_op(3'b001, 6'd3, d, done, pe);
    check("par_bad_data", d, 16'h3C3C);
    check("par_bad_pulse", pe, 1);
    rd_op(3'b001, 6'd4, d, done, pe);
    check("par_clean_data", d, 16'h4D4D);
    check("par_clean_pulse", pe, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
